// File: rtl/seg_to_hex_capture_if.sv
// Capture-side bus of seg_to_hex_capture: segment input, load strobe and the
// assembled word with its status flags.
interface seg_to_hex_capture_if #(
  parameter int NIBBLES = 2
);
  logic [6:0]           seg_in;
  logic                 load;
  logic [4*NIBBLES-1:0] value;
  logic                 valid;
  logic                 error;
  logic [3:0]           count;

  modport master (output seg_in, output load,
                  input value, input valid, input error, input count);
  modport slave  (input seg_in, input load,
                  output value, output valid, output error, output count);
endinterface

// File: rtl/seg_to_hex_capture.sv
// Decodes 7-segment patterns back into hex nibbles and assembles them, one per
// rising edge of load, into a NIBBLES-wide word with legality checking.
module seg_to_hex_capture #(
  parameter int NIBBLES    = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  clear_b,
  seg_to_hex_capture_if.slave   bus
);

  localparam int         VW       = 4 * NIBBLES;
  localparam logic [3:0] FULL_CNT = 4'(NIBBLES);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  // Returns {legal, nibble} for an active-low segment pattern (bit0 = a).
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h40:   seg_decode = {1'b1, 4'h0};
      7'h79:   seg_decode = {1'b1, 4'h1};
      7'h24:   seg_decode = {1'b1, 4'h2};
      7'h30:   seg_decode = {1'b1, 4'h3};
      7'h19:   seg_decode = {1'b1, 4'h4};
      7'h12:   seg_decode = {1'b1, 4'h5};
      7'h02:   seg_decode = {1'b1, 4'h6};
      7'h78:   seg_decode = {1'b1, 4'h7};
      7'h00:   seg_decode = {1'b1, 4'h8};
      7'h10:   seg_decode = {1'b1, 4'h9};
      7'h08:   seg_decode = {1'b1, 4'hA};
      7'h03:   seg_decode = {1'b1, 4'hB};
      7'h46:   seg_decode = {1'b1, 4'hC};
      7'h21:   seg_decode = {1'b1, 4'hD};
      7'h06:   seg_decode = {1'b1, 4'hE};
      7'h0E:   seg_decode = {1'b1, 4'hF};
      default: seg_decode = {1'b0, 4'h0};
    endcase
  endfunction

  state_t          state_r, state_nxt_s;
  logic            load_q_r;
  logic [VW-1:0]   value_r, value_nxt_s, value_shift_s;
  logic [3:0]      count_r, count_nxt_s;
  logic            valid_r, valid_nxt_s;
  logic            error_r, error_nxt_s;
  logic [6:0]      seg_norm_s;
  logic [4:0]      dec_s;
  logic            legal_s;
  logic [3:0]      nibble_s;
  logic            cap_s;

  assign seg_norm_s    = (ACTIVE_LOW != 0) ? bus.seg_in : ~bus.seg_in;
  assign dec_s         = seg_decode(seg_norm_s);
  assign legal_s       = dec_s[4];
  assign nibble_s      = dec_s[3:0];
  assign cap_s         = bus.load & ~load_q_r;
  // Shift form collapses to a plain load of the nibble when NIBBLES is 1.
  assign value_shift_s = (value_r << 3'd4) | VW'(nibble_s);

  // Load edge detector; resets high so a load held through reset is ignored.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      load_q_r <= 1'b1;
    end else begin
      load_q_r <= bus.load;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state_r <= EMPTY;
      value_r <= '0;
      count_r <= 4'd0;
      valid_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      value_r <= value_nxt_s;
      count_r <= count_nxt_s;
      valid_r <= valid_nxt_s;
      error_r <= error_nxt_s;
    end
  end

  // Next-state and next-output logic; only capture cycles change anything.
  always_comb begin
    state_nxt_s = state_r;
    value_nxt_s = value_r;
    count_nxt_s = count_r;
    valid_nxt_s = valid_r;
    error_nxt_s = error_r;
    if (cap_s && legal_s) begin
      value_nxt_s = value_shift_s;
      error_nxt_s = 1'b0;
      case (state_r)
        EMPTY, PARTIAL: begin
          count_nxt_s = count_r + 4'd1;
          if ((count_r + 4'd1) == FULL_CNT) begin
            state_nxt_s = FULL;
            valid_nxt_s = 1'b1;
          end else begin
            state_nxt_s = PARTIAL;
            valid_nxt_s = 1'b0;
          end
        end
        FULL: begin
          count_nxt_s = 4'd1;
          if (FULL_CNT == 4'd1) begin
            state_nxt_s = FULL;
            valid_nxt_s = 1'b1;
          end else begin
            state_nxt_s = PARTIAL;
            valid_nxt_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
          count_nxt_s = 4'd0;
          valid_nxt_s = 1'b0;
        end
      endcase
    end else if (cap_s) begin
      // Illegal pattern: drop the partial word but keep the last value visible.
      state_nxt_s = EMPTY;
      count_nxt_s = 4'd0;
      valid_nxt_s = 1'b0;
      error_nxt_s = 1'b1;
    end else begin
      state_nxt_s = state_r;
      value_nxt_s = value_r;
    end
  end

  assign bus.value = value_r;
  assign bus.count = count_r;
  assign bus.valid = valid_r;
  assign bus.error = error_r;

endmodule

// File: tb/tb_seg_to_hex_capture.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// a randomized run against an arithmetic reference model on three instances.
module tb_seg_to_hex_capture;

  logic clk = 1'b0;
  logic clear_b = 1'b0;
  always #5 clk = ~clk;

  seg_to_hex_capture_if #(.NIBBLES(2)) if_lo ();
  seg_to_hex_capture_if #(.NIBBLES(2)) if_hi ();
  seg_to_hex_capture_if #(.NIBBLES(1)) if_n1 ();

  seg_to_hex_capture #(.NIBBLES(2), .ACTIVE_LOW(1)) u_lo (.clk(clk), .clear_b(clear_b), .bus(if_lo));
  seg_to_hex_capture #(.NIBBLES(2), .ACTIVE_LOW(0)) u_hi (.clk(clk), .clear_b(clear_b), .bus(if_hi));
  seg_to_hex_capture #(.NIBBLES(1), .ACTIVE_LOW(1)) u_n1 (.clk(clk), .clear_b(clear_b), .bus(if_n1));

  typedef struct {
    logic [6:0] seg;
    logic [7:0] val;
    logic [3:0] cnt;
    logic       vld;
    logic       err;
  } vec_t;

  vec_t        vecs[$];
  logic [6:0]  pat_tbl [16];
  int          n_vec = 0;
  int          n_err = 0;

  longint      m_val [2];
  int          m_cnt [2];
  bit          m_vld [2];
  bit          m_err [2];
  bit          m_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_lo(input logic [6:0] seg);
    if_lo.seg_in = seg;
    if_lo.load   = 1'b1;
    cyc();
    if_lo.load   = 1'b0;
    cyc();
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0;
      m_cnt[i] = 0;
      m_vld[i] = 1'b0;
      m_err[i] = 1'b0;
    end
    m_prev = 1'b1;
  endfunction

  function automatic void model_cap(input int i, input logic [6:0] seg, input int n);
    int nib = -1;
    for (int k = 0; k < 16; k++)
      if (pat_tbl[k] == seg) nib = k;
    if (nib < 0) begin
      m_cnt[i] = 0;
      m_vld[i] = 1'b0;
      m_err[i] = 1'b1;
    end else begin
      if (m_cnt[i] == n) m_cnt[i] = 0;
      m_val[i] = ((m_val[i] << 4) | longint'(nib)) & ((64'd1 << (4 * n)) - 64'd1);
      m_cnt[i]++;
      m_vld[i] = (m_cnt[i] == n);
      m_err[i] = 1'b0;
    end
  endfunction

  initial begin
    pat_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    vecs.push_back('{seg: 7'h08, val: 8'h0A, cnt: 4'd1, vld: 1'b0, err: 1'b0});
    vecs.push_back('{seg: 7'h10, val: 8'hA9, cnt: 4'd2, vld: 1'b1, err: 1'b0});
    vecs.push_back('{seg: 7'h0E, val: 8'h9F, cnt: 4'd1, vld: 1'b0, err: 1'b0});
    for (int k = 0; k < 16; k++) begin
      logic [3:0] prv;
      prv = (k == 0) ? 4'hF : 4'(k - 1);
      vecs.push_back('{seg: pat_tbl[k], val: {prv, 4'(k)},
                       cnt: ((k % 2) == 0) ? 4'd2 : 4'd1,
                       vld: ((k % 2) == 0), err: 1'b0});
    end
    vecs.push_back('{seg: 7'h7F, val: 8'hEF, cnt: 4'd0, vld: 1'b0, err: 1'b1});
    vecs.push_back('{seg: 7'h40, val: 8'hF0, cnt: 4'd1, vld: 1'b0, err: 1'b0});

    // Reset with load held high, then keep it high after release.
    if_lo.seg_in = 7'h40; if_hi.seg_in = 7'h3F; if_n1.seg_in = 7'h40;
    if_lo.load = 1'b1; if_hi.load = 1'b1; if_n1.load = 1'b1;
    clear_b = 1'b0;
    cyc(); cyc();
    clear_b = 1'b1;
    repeat (5) cyc();
    check("held-load value", 32'(if_lo.value), 32'h00);
    check("held-load count", 32'(if_lo.count), 32'd0);
    check("held-load valid", 32'(if_lo.valid), 32'd0);
    check("held-load error", 32'(if_lo.error), 32'd0);
    if_lo.load = 1'b0; if_hi.load = 1'b0; if_n1.load = 1'b0;
    cyc();

    // Directed table: word assembly, restart from full, sweep, illegal pattern.
    foreach (vecs[i]) begin
      pulse_lo(vecs[i].seg);
      check($sformatf("vec%0d value", i), 32'(if_lo.value), 32'(vecs[i].val));
      check($sformatf("vec%0d count", i), 32'(if_lo.count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d valid", i), 32'(if_lo.valid), 32'(vecs[i].vld));
      check($sformatf("vec%0d error", i), 32'(if_lo.error), 32'(vecs[i].err));
    end

    // Asynchronous clear between edges discards a partial word.
    pulse_lo(7'h79);
    check("pre-clear count", 32'(if_lo.count), 32'd2);
    pulse_lo(7'h24);
    check("pre-clear count2", 32'(if_lo.count), 32'd1);
    #2 clear_b = 1'b0;
    #1;
    check("async value", 32'(if_lo.value), 32'h00);
    check("async count", 32'(if_lo.count), 32'd0);
    check("async valid", 32'(if_lo.valid), 32'd0);
    check("async error", 32'(if_lo.error), 32'd0);
    cyc();
    clear_b = 1'b1;
    cyc();

    // Active-high instance: 0x3F then 0x06 are digits 0 and 1.
    if_hi.seg_in = 7'h3F; if_hi.load = 1'b1; cyc(); if_hi.load = 1'b0; cyc();
    if_hi.seg_in = 7'h06; if_hi.load = 1'b1; cyc(); if_hi.load = 1'b0; cyc();
    check("act-high value", 32'(if_hi.value), 32'h01);
    check("act-high valid", 32'(if_hi.valid), 32'd1);
    check("act-high count", 32'(if_hi.count), 32'd2);
    check("act-high error", 32'(if_hi.error), 32'd0);

    // Randomized run against the reference model, with occasional mid-cycle clears.
    if_lo.load = 1'b0; if_hi.load = 1'b0; if_n1.load = 1'b0;
    clear_b = 1'b0;
    cyc(); cyc();
    clear_b = 1'b1;
    model_reset();
    for (int t = 0; t < 600; t++) begin
      logic [6:0] seg;
      logic       ld;
      ld = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) seg = pat_tbl[$urandom_range(0, 15)];
      else seg = 7'($urandom_range(0, 127));
      if_lo.seg_in = seg; if_hi.seg_in = ~seg; if_n1.seg_in = seg;
      if_lo.load = ld; if_hi.load = ld; if_n1.load = ld;
      if ($urandom_range(0, 63) == 0) begin
        #2 clear_b = 1'b0;
        #1 clear_b = 1'b1;
        model_reset();
        m_prev = ld;
      end else begin
        if (ld && !m_prev) begin
          model_cap(0, seg, 2);
          model_cap(1, seg, 1);
        end
        m_prev = ld;
      end
      cyc();
      check("rnd lo value", 32'(if_lo.value), 32'(m_val[0]));
      check("rnd lo count", 32'(if_lo.count), 32'(m_cnt[0]));
      check("rnd lo valid", 32'(if_lo.valid), 32'(m_vld[0]));
      check("rnd lo error", 32'(if_lo.error), 32'(m_err[0]));
      check("rnd hi value", 32'(if_hi.value), 32'(m_val[0]));
      check("rnd hi count", 32'(if_hi.count), 32'(m_cnt[0]));
      check("rnd hi valid", 32'(if_hi.valid), 32'(m_vld[0]));
      check("rnd hi error", 32'(if_hi.error), 32'(m_err[0]));
      check("rnd n1 value", 32'(if_n1.value), 32'(m_val[1]));
      check("rnd n1 count", 32'(if_n1.count), 32'(m_cnt[1]));
      check("rnd n1 valid", 32'(if_n1.valid), 32'(m_vld[1]));
      check("rnd n1 error", 32'(if_n1.error), 32'(m_err[1]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
